// File: rtl/popcnt_pkg.sv
// Shared definitions for consumers of the 16-bit combinational ones-counter.
// Holds the per-word count range and the frame accumulator state encoding.
package popcnt_pkg;

    // Largest legal ones count for a 16-bit word, and the width that carries it.
    localparam int unsigned MAX_ONES = 16;
    localparam int unsigned ONES_W   = 5;

    typedef enum logic {
        StAcc  = 1'b0,
        StHold = 1'b1
    } acc_state_e;

endpackage

// File: rtl/ones_clamp.sv
// Saturates a per-word ones count to the legal range and flags counts that had to be clamped.
// Purely combinational so that any consumer of the ones-counter can reuse it.
module ones_clamp
    import popcnt_pkg::*;
(
    input  logic [ONES_W-1:0] in_ones,
    output logic [ONES_W-1:0] v,
    output logic              err_bit
);

    always_comb begin
        err_bit = (in_ones > ONES_W'(MAX_ONES));
        v       = err_bit ? ONES_W'(MAX_ONES) : in_ones;
    end

endmodule

// File: rtl/ones_frame_acc.sv
// Accumulates clamped per-word ones counts over a frame and presents one registered result
// per frame behind a valid/ready handshake.
module ones_frame_acc
    import popcnt_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned SUM_W     = 8,
    parameter int unsigned WCNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ONES_W-1:0] in_ones,
    input  logic              in_last,
    input  logic [SUM_W-1:0]  thresh,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [WCNT_W-1:0] out_words,
    output logic [ONES_W-1:0] out_max,
    output logic              out_over,
    output logic              out_err
);

    acc_state_e        state_q, state_d;
    logic [SUM_W-1:0]  acc_sum_q, acc_sum_d;
    logic [WCNT_W-1:0] acc_words_q, acc_words_d;
    logic [ONES_W-1:0] acc_max_q, acc_max_d;
    logic              acc_err_q, acc_err_d;

    logic [SUM_W-1:0]  out_sum_q, out_sum_d;
    logic [WCNT_W-1:0] out_words_q, out_words_d;
    logic [ONES_W-1:0] out_max_q, out_max_d;
    logic              out_over_q, out_over_d;
    logic              out_err_q, out_err_d;

    logic [ONES_W-1:0] v;
    logic              clamp_err;
    logic              accept;
    logic              close;
    logic [SUM_W-1:0]  sum_upd;
    logic [WCNT_W-1:0] words_upd;
    logic [ONES_W-1:0] max_upd;
    logic              err_upd;

    ones_clamp u_clamp (
        .in_ones (in_ones),
        .v       (v),
        .err_bit (clamp_err)
    );

    // Handshake flags come straight from the state register; no path from out_ready.
    assign in_ready  = (state_q == StAcc);
    assign out_valid = (state_q == StHold);

    assign out_sum   = out_sum_q;
    assign out_words = out_words_q;
    assign out_max   = out_max_q;
    assign out_over  = out_over_q;
    assign out_err   = out_err_q;

    // Running values including the word on the inputs; the SUM_W sizing rule keeps the sum from
    // wrapping, so a plain add is enough.
    always_comb begin
        accept    = in_valid && (state_q == StAcc);
        sum_upd   = acc_sum_q + SUM_W'(v);
        words_upd = acc_words_q + WCNT_W'(1);
        max_upd   = (v > acc_max_q) ? v : acc_max_q;
        err_upd   = acc_err_q | clamp_err;
        close     = accept && ((words_upd == WCNT_W'(FRAME_LEN)) || in_last);
    end

    always_comb begin
        state_d     = state_q;
        acc_sum_d   = acc_sum_q;
        acc_words_d = acc_words_q;
        acc_max_d   = acc_max_q;
        acc_err_d   = acc_err_q;
        out_sum_d   = out_sum_q;
        out_words_d = out_words_q;
        out_max_d   = out_max_q;
        out_over_d  = out_over_q;
        out_err_d   = out_err_q;

        case (state_q)
            StAcc: begin
                if (close) begin
                    // The closing word is part of the result; accumulators restart empty.
                    out_sum_d   = sum_upd;
                    out_words_d = words_upd;
                    out_max_d   = max_upd;
                    out_over_d  = (sum_upd >= thresh);
                    out_err_d   = err_upd;
                    acc_sum_d   = '0;
                    acc_words_d = '0;
                    acc_max_d   = '0;
                    acc_err_d   = 1'b0;
                    state_d     = StHold;
                end else if (accept) begin
                    acc_sum_d   = sum_upd;
                    acc_words_d = words_upd;
                    acc_max_d   = max_upd;
                    acc_err_d   = err_upd;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StAcc;
                end
            end
            default: state_d = StAcc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StAcc;
            acc_sum_q   <= '0;
            acc_words_q <= '0;
            acc_max_q   <= '0;
            acc_err_q   <= 1'b0;
            out_sum_q   <= '0;
            out_words_q <= '0;
            out_max_q   <= '0;
            out_over_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_sum_q   <= acc_sum_d;
            acc_words_q <= acc_words_d;
            acc_max_q   <= acc_max_d;
            acc_err_q   <= acc_err_d;
            out_sum_q   <= out_sum_d;
            out_words_q <= out_words_d;
            out_max_q   <= out_max_d;
            out_over_q  <= out_over_d;
            out_err_q   <= out_err_d;
        end
    end

endmodule

// File: tb/tb_ones_frame_acc.sv
// Directed and randomized bench for ones_frame_acc against a frame-level reference model.
module tb_ones_frame_acc;

    localparam int FL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_ones = '0;
    logic       in_last = 1'b0;
    logic [7:0] thresh = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_sum;
    logic [3:0] out_words;
    logic [4:0] out_max;
    logic       out_over;
    logic       out_err;

    ones_frame_acc #(.FRAME_LEN(FL), .SUM_W(8), .WCNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ones   (in_ones),
        .in_last   (in_last),
        .thresh    (thresh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_words (out_words),
        .out_max   (out_max),
        .out_over  (out_over),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: words of the open frame, whether a result is pending, and its contents.
    int frame[$];
    bit m_hold = 0;
    bit m_outs_known = 1;
    int e_sum = 0, e_words = 0, e_max = 0, e_over = 0, e_err = 0;
    int frames_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic close_frame();
        int s = 0, mx = 0, er = 0;
        foreach (frame[i]) begin
            int w = (frame[i] > 16) ? 16 : frame[i];
            s += w;
            if (w > mx) mx = w;
            if (frame[i] > 16) er = 1;
        end
        e_sum = s; e_words = frame.size(); e_max = mx; e_err = er;
        e_over = (s >= int'(thresh)) ? 1 : 0;
        frame.delete();
        m_hold = 1;
        m_outs_known = 1;
        frames_done++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_hold));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_hold));
        if (m_outs_known) begin
            chk({tag, ".out_sum"}, 32'(out_sum), e_sum);
            chk({tag, ".out_words"}, 32'(out_words), e_words);
            chk({tag, ".out_max"}, 32'(out_max), e_max);
            chk({tag, ".out_over"}, 32'(out_over), e_over);
            chk({tag, ".out_err"}, 32'(out_err), e_err);
        end
    endtask

    // One clock: apply the model for the coming edge, then check #1 after it.
    task automatic cyc(input string tag);
        if (!m_hold && in_valid) begin
            frame.push_back(int'(in_ones));
            if (frame.size() == FL || in_last) close_frame();
        end else if (m_hold && out_ready) begin
            m_hold = 0;
            m_outs_known = 0;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic word(input string tag, input int ones, input bit last);
        in_valid = 1'b1;
        in_ones  = 5'(ones);
        in_last  = last;
        cyc(tag);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst = 1'b1;
        frame.delete();
        m_hold = 0;
        m_outs_known = 1;
        e_sum = 0; e_words = 0; e_max = 0; e_over = 0; e_err = 0;
        #2;
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    int frames_before;

    initial begin
        // Power-on reset and reset state.
        do_reset("reset0");

        // Reset in the middle of a frame discards the partial words.
        out_ready = 1'b1;
        thresh = 8'd100;
        word("pre_rst", 5, 0);
        word("pre_rst", 7, 0);
        word("pre_rst", 9, 0);
        do_reset("reset_mid");

        // Full frame of saturating counts.
        for (int i = 0; i < FL; i++) word("full16", 16, 0);
        chk("full16.sum_const", 32'(out_sum), 128);
        cyc("full16_hs");

        // Early close on in_last; in_ready low for the hold cycle.
        thresh = 8'd9;
        word("short", 3, 0);
        word("short", 0, 0);
        word("short", 5, 1);
        chk("short.sum_const", 32'(out_sum), 8);
        chk("short.ready_const", 32'(in_ready), 0);
        cyc("short_hs");

        // Back-pressure with in_valid held high through the hold.
        out_ready = 1'b0;
        thresh = 8'd40;
        for (int i = 0; i < FL; i++) word("bp_fill", i + 2, 0);
        in_valid = 1'b1;
        in_ones = 5'd11;
        for (int i = 0; i < 5; i++) cyc("bp_hold");
        out_ready = 1'b1;
        cyc("bp_hs");
        cyc("bp_next");
        in_valid = 1'b0;
        chk("bp.words_in_frame", 32'(frame.size()), 1);

        // Clamped count sets err; the next clean frame does not.
        thresh = 8'd17;
        word("err", 20, 0);
        word("err", 1, 1);
        chk("err.err_const", 32'(out_err), 1);
        cyc("err_hs");
        word("clean", 4, 0);
        word("clean", 6, 1);
        chk("clean.err_const", 32'(out_err), 0);
        cyc("clean_hs");
        // Flush the one extra word left from the back-pressure step is already closed above.

        // in_last on the final word of a full frame: exactly one close.
        frames_before = frames_done;
        for (int i = 0; i < FL; i++) word("last_full", 1, i == FL - 1);
        cyc("last_full_hs");
        cyc("last_full_idle");
        chk("last_full.frames", 32'(frames_done - frames_before), 1);

        // Toggling in_valid over 16 cycles forms one 8-word frame.
        frames_before = frames_done;
        thresh = 8'd50;
        for (int i = 0; i < 16; i++) begin
            in_valid = ~i[0];
            in_ones  = 5'($urandom_range(0, 16));
            in_last  = 1'b0;
            cyc("toggle");
        end
        in_valid = 1'b0;
        chk("toggle.frames", 32'(frames_done - frames_before), 1);
        chk("toggle.words_const", 32'(out_words), 8);
        cyc("toggle_hs");

        // Randomized traffic, back-pressure, early closes, illegal counts and thresh changes.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ones   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31))
                                                    : 5'($urandom_range(0, 16));
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 4) == 0) thresh = 8'($urandom_range(0, 140));
            cyc("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
